// File: rtl/mem_access_unit.sv
// mem_access_unit: multicycle load/store controller, IDLE/ACCESS/DONE.
// Define MEM_TIMEOUT_EN to abort accesses after TIMEOUT_CYCLES wait states.
module mem_access_unit #(
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req,
   input  logic                  we,
   input  logic [DATA_WIDTH-1:0] addr,
   input  logic [1:0]            size,
   input  logic                  uns,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic [3:0]            mem_be,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   logic [1:0]            state_q, state_d;
   logic                  we_q, uns_q, err_q;
   logic [1:0]            size_q, off_q;
   logic [3:0]            be_q, be_d;
   logic [DATA_WIDTH-1:0] addr_q, wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, ld_data;
   logic [7:0]            lane_b;
   logic [15:0]           lane_h;
   logic                  bad, timeout;

`ifdef MEM_TIMEOUT_EN
   logic [31:0] cnt_q;

   assign timeout = (cnt_q == 32'(TIMEOUT_CYCLES - 1));

   // Wait-state counter: zero outside ACCESS, counts cycles without ack.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (state_q != S_ACCESS) begin
         cnt_q <= '0;
      end else if (!mem_ack) begin
         cnt_q <= cnt_q + 32'd1;
      end
   end
`else
   logic [31:0] unused_timeout;

   assign timeout        = 1'b0;
   assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

   // Alignment check, byte-lane enables and lane-replicated store data.
   always_comb begin
      bad     = 1'b0;
      be_d    = 4'b1111;
      wdata_d = wdata;
      unique case (size)
         2'b00: begin
            be_d    = 4'b0001 << addr[1:0];
            wdata_d = {4{wdata[7:0]}};
         end
         2'b01: begin
            bad     = addr[0];
            be_d    = 4'b0011 << addr[1:0];
            wdata_d = {2{wdata[15:0]}};
         end
         2'b10: bad = |addr[1:0];
         default: bad = 1'b1;
      endcase
   end

   // Select the addressed lane and extend it to a full word.
   always_comb begin
      lane_b = mem_rdata[7:0];
      unique case (off_q)
         2'd1: lane_b = mem_rdata[15:8];
         2'd2: lane_b = mem_rdata[23:16];
         2'd3: lane_b = mem_rdata[31:24];
         default: lane_b = mem_rdata[7:0];
      endcase
      lane_h  = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      ld_data = mem_rdata;
      unique case (size_q)
         2'b00: ld_data = {{(DATA_WIDTH-8){~uns_q & lane_b[7]}}, lane_b};
         2'b01: ld_data = {{(DATA_WIDTH-16){~uns_q & lane_h[15]}}, lane_h};
         default: ld_data = mem_rdata;
      endcase
   end

   // Next-state logic; illegal requests skip the memory entirely.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (req) state_d = bad ? S_DONE : S_ACCESS;
         S_ACCESS: if (mem_ack || timeout) state_d = S_DONE;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // State, latched request controls and the held load result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         err_q   <= 1'b0;
         size_q  <= 2'b00;
         off_q   <= 2'b00;
         be_q    <= 4'b0000;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_IDLE && req) begin
            err_q <= bad;
            if (!bad) begin
               we_q    <= we;
               uns_q   <= uns;
               size_q  <= size;
               off_q   <= addr[1:0];
               be_q    <= be_d;
               addr_q  <= {addr[DATA_WIDTH-1:2], 2'b00};
               wdata_q <= wdata_d;
            end
         end
         if (state_q == S_ACCESS) begin
            if (mem_ack) begin
               if (!we_q) rdata_q <= ld_data;
            end else if (timeout) begin
               err_q <= 1'b1;
            end
         end
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign err       = done & err_q;
   assign rdata     = rdata_q;
   assign mem_req   = (state_q == S_ACCESS);
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_be    = be_q;
   assign mem_wdata = wdata_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

- Multicycle load/store controller between the datapath and data memory; its load result feeds the data register stage directly.
- Accepts one access request at a time, drives a word-addressed memory port with byte enables, and waits for the memory acknowledge.
- Extracts and sign- or zero-extends load data, then holds the result stable on `rdata` so the downstream register can sample it on any later edge.

## Interface
Parameters:
- `DATA_WIDTH`, 32, datapath and memory word width (fixed 4 byte lanes; only 32 supported)
- `TIMEOUT_CYCLES`, 255, wait-state limit before abort (used only with `MEM_TIMEOUT_EN`)

Ports (one clock `clk`; reset `rst_n` is asynchronous, active-low):
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `req`  in  1  access request, sampled only in IDLE
- `we`  in  1  1 = store, 0 = load
- `addr`  in  32  byte address
- `size`  in  2  00 byte, 01 half, 10 word, 11 illegal
- `uns`  in  1  1 = zero-extend load, 0 = sign-extend
- `wdata`  in  32  store data, right-justified
- `busy`  out  1  high from the cycle after `req` is accepted until `done`, inclusive
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  valid with `done`; misaligned/illegal access or timeout
- `rdata`  out  32  extended load result; held until the next successful load
- `mem_req`  out  1  memory request, held until `mem_ack`
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  32  word address: `{addr[31:2],2'b00}`
- `mem_be`  out  4  byte enables, little-endian lanes
- `mem_wdata`  out  32  lane-replicated store data
- `mem_ack`  in  1  memory completion; may be asserted in the same cycle as `mem_req`
- `mem_rdata`  in  32  read word, valid while `mem_ack` is high

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE, with `req`=1 and a legal, aligned access:
  - register `we`, `size`, `uns`, `addr[1:0]`, `mem_addr`, `mem_be`, `mem_wdata`
  - go to ACCESS
- IDLE, with `req`=1 and a misaligned or illegal access: go to DONE with `err`=1; no memory request is issued. An access is misaligned or illegal when:
  - half with `addr[0]`=1, or
  - word with `addr[1:0]`≠0, or
  - `size`=11
- ACCESS:
  - `mem_req`=1 with registered controls
  - on `mem_ack`, capture the load result (loads only) and go to DONE
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- Byte enables:
  - byte: `4'b0001<<addr[1:0]`
  - half: `4'b0011<<addr[1:0]`
  - word: `4'b1111`
- Store data: byte replicated ×4; half replicated ×2; word as-is.
- Load extraction:
  - byte lane = `addr[1:0]`; half lane = `addr[1]`
  - extend to 32 bits from bit 7 or bit 15 unless `uns`=1
  - words pass through unchanged
- `rdata` updates only on a successful load. Stores, errors and timeouts leave `rdata` unchanged.
- `req` while not IDLE is ignored; there is no queueing.

## Timing
- Reset (asynchronous, any state): IDLE; every output is 0, including `rdata`, `mem_be` and `mem_addr`. An in-flight `mem_req` drops immediately. An ack arriving after reset is ignored.
- Legal access, `req` in cycle 0:
  - `mem_req` from cycle 1
  - ack in cycle N≥1 → `done` in cycle N+1; `rdata` is valid from cycle N+1
  - minimum latency is 2 cycles
- Illegal access, `req` in cycle 0: `done`=`err`=1 in cycle 1; latency 1.
- `mem_req`, `mem_we`, `mem_addr`, `mem_be` and `mem_wdata` are registered and stable throughout ACCESS.
- Earliest next acceptance: the cycle after `done`. Back-to-back throughput is one access per 3 cycles with zero wait states.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - a wait counter clears on entry to ACCESS and increments each ACCESS cycle without `mem_ack`
  - when the count reaches `TIMEOUT_CYCLES`, drop `mem_req` and go to DONE with `err`=1
  - `mem_ack` in the same cycle as the limit takes priority (normal completion)
- Undefined: no counter; ACCESS waits indefinitely. `err` reports misaligned/illegal accesses only, and `TIMEOUT_CYCLES` is ignored.

## Test plan
- Byte load, `addr`=0x103, `uns`=0, `mem_rdata`=0x80FF_1234, ack on first cycle:
  - `mem_be`=1000
  - `done` cycle 2, `rdata`=0xFFFF_FF80
  - repeat with `uns`=1 → 0x0000_0080
- Half store, `addr`=0x22, `wdata`=0xABCD_BEEF:
  - `mem_addr`=0x20, `mem_be`=1100, `mem_wdata`=0xBEEF_BEEF, `mem_we`=1
  - `rdata` unchanged
- Word load at 0x46 → `done`=`err`=1 in cycle 1, `mem_req` never asserts. Same for `size`=11.
- Word load with ack delayed 5 cycles → `mem_req` high cycles 1–6, `done` cycle 7; a `req` pulse during ACCESS is ignored.
- Assert `rst_n`=0 mid-ACCESS:
  - `mem_req`, `busy` and `rdata` go to 0 asynchronously
  - after release, a late `mem_ack` produces no `done`
- With `MEM_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, no ack → `mem_req` drops after 4 ACCESS cycles, then `done`=`err`=1 next cycle.
